// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        addr_error;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_readData;

    // Load/store unit view
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_readData,
        output busy, done, load_data, addr_error,
        output mem_address, mem_writeData, mem_memWrite, mem_memRead
    );

    // Pipeline and data-memory view
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_readData,
        input  busy, done, load_data, addr_error,
        input  mem_address, mem_writeData, mem_memWrite, mem_memRead
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle big-endian load/store unit with read-modify-write sub-word stores
module load_store_unit (
    input  logic             clock,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic        signed_q;
    logic        write_q;
    logic [31:0] address_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data_q;
    logic        addr_error_q;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Reserved size or an address not aligned to the access size never touches memory
    assign misaligned = (bus.req_size == 2'b11)
                     || ((bus.req_size == 2'b01) && bus.req_addr[0])
                     || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == RESP);
    assign bus.mem_memRead   = (state == READ);
    assign bus.mem_memWrite  = (state == WRITE);
    assign bus.mem_address   = address_q;
    assign bus.mem_writeData = wdata_q;
    assign bus.load_data     = load_data_q;
    assign bus.addr_error    = addr_error_q;

    // State register; reset abandons any access in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Routing: loads and sub-word stores read first, word stores write directly
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (!bus.req_write) begin
                        state_next = READ;
                    end else if (bus.req_size == 2'b10) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = write_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Big-endian lane select for loads and lane merge for sub-word stores
    always_comb begin
        byte_lane = bus.mem_readData[31:24];
        case (offset_q)
            2'd0:    byte_lane = bus.mem_readData[31:24];
            2'd1:    byte_lane = bus.mem_readData[23:16];
            2'd2:    byte_lane = bus.mem_readData[15:8];
            default: byte_lane = bus.mem_readData[7:0];
        endcase
        half_lane = offset_q[1] ? bus.mem_readData[15:0] : bus.mem_readData[31:16];

        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'd0, byte_lane};
            2'b01:   load_ext = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'd0, half_lane};
            default: load_ext = bus.mem_readData;
        endcase

        merged = bus.mem_readData;
        if (size_q == 2'b00) begin
            case (offset_q)
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (offset_q[1]) begin
                merged[15:0] = wdata_q[15:0];
            end else begin
                merged[31:16] = wdata_q[15:0];
            end
        end
    end

    // Request capture on acceptance, read-data capture at the end of READ, result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            size_q       <= 2'b00;
            offset_q     <= 2'b00;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            wdata_q      <= 32'd0;
            load_data_q  <= 32'd0;
            addr_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_q    <= bus.req_size;
                        offset_q  <= bus.req_addr[1:0];
                        signed_q  <= bus.req_signed;
                        write_q   <= bus.req_write;
                        address_q <= {bus.req_addr[31:2], 2'b00};
                        wdata_q   <= bus.req_wdata;
                        if (misaligned) begin
                            addr_error_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (write_q) begin
                        wdata_q <= merged;
                    end else begin
                        load_data_q  <= load_ext;
                        addr_error_q <= 1'b0;
                    end
                end
                WRITE:   addr_error_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-addressed memory model
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    load_store_unit_if bus();
    load_store_unit dut (.clock(clock), .reset(reset), .bus(bus));

    logic [31:0] mem [0:63];
    logic [7:0]  rb  [0:255];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'd0;

    int checks = 0;
    int passed = 0;

    int rd_total = 0;
    int wr_total = 0;
    int both_total = 0;
    int done_total = 0;
    int long_done = 0;
    logic done_prev = 1'b0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;
    logic [31:0] last_ra = 32'd0;

    assign bus.mem_readData = mem[bus.mem_address[7:2]];

    // Data memory: unit writes, plus a preload port used by the bench
    always @(posedge clock) begin
        if (bus.mem_memWrite) begin
            mem[bus.mem_address[7:2]] <= bus.mem_writeData;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    // Bus activity monitor
    always @(negedge clock) begin
        if (bus.mem_memRead) begin
            rd_total++;
            last_ra = bus.mem_address;
        end
        if (bus.mem_memWrite) begin
            wr_total++;
            last_wa = bus.mem_address;
            last_wd = bus.mem_writeData;
        end
        if (bus.mem_memRead && bus.mem_memWrite) both_total++;
        if (bus.done) done_total++;
        if (bus.done && done_prev) long_done++;
        done_prev = bus.done;
    end

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & 32'hFC;
        return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
    endfunction

    function automatic logic ref_bad(input logic [1:0] sz, input int a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input int a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = {24'd0, rb[a]};
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = {16'd0, rb[a], rb[a+1]};
            if (sg && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = ref_word(a);
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
        if (sz == 2'd0) begin
            rb[a] = wd[7:0];
        end else if (sz == 2'd1) begin
            rb[a] = wd[15:8];
            rb[a+1] = wd[7:0];
        end else begin
            rb[a] = wd[31:24];
            rb[a+1] = wd[23:16];
            rb[a+2] = wd[15:8];
            rb[a+3] = wd[7:0];
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        int b;
        b = a & 32'hFC;
        @(negedge clock);
        pre_we = 1'b1;
        pre_idx = 6'(b / 4);
        pre_data = v;
        rb[b] = v[31:24];
        rb[b+1] = v[23:16];
        rb[b+2] = v[15:8];
        rb[b+3] = v[7:0];
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic run_access(input logic w, input logic [1:0] sz, input logic sg, input int a,
                              input logic [31:0] wd, input logic junk,
                              output int lat, output logic [31:0] ld, output logic ae,
                              output int nrd, output int nwr, output int waited);
        int rd0;
        int wr0;
        waited = 0;
        @(negedge clock);
        while (bus.busy && waited < 10) begin
            waited++;
            @(negedge clock);
        end
        rd0 = rd_total;
        wr0 = wr_total;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size = sz;
        bus.req_signed = sg;
        bus.req_addr = 32'(a);
        bus.req_wdata = wd;
        lat = -1;
        ld = 32'hx;
        ae = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (bus.done) begin
                lat = k;
                ld = bus.load_data;
                ae = bus.addr_error;
                break;
            end
            bus.req_valid = junk;
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_size = 2'($urandom_range(0, 3));
            bus.req_signed = 1'($urandom_range(0, 1));
            bus.req_addr = $urandom;
            bus.req_wdata = $urandom;
        end
        bus.req_valid = 1'b0;
        nrd = rd_total - rd0;
        nwr = wr_total - wr0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.done, bus.addr_error, bus.mem_memRead, bus.mem_memWrite} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.busy, bus.done, bus.addr_error, bus.mem_memRead, bus.mem_memWrite});
        else passed++;
        checks++;
        if (bus.load_data !== 32'd0) $display("FAIL reset_load_data: got %h expected 0", bus.load_data);
        else passed++;
        checks++;
        if (bus.mem_address !== 32'd0) $display("FAIL reset_mem_address: got %h expected 0", bus.mem_address);
        else passed++;
        checks++;
        if (bus.mem_writeData !== 32'd0) $display("FAIL reset_mem_writeData: got %h expected 0", bus.mem_writeData);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic init_memory;
        for (int i = 0; i < 64; i++) set_word(i * 4, $urandom);
    endtask

    task automatic test_signed_byte_load;
        int lat, nrd, nwr, waited;
        logic [31:0] ld;
        logic ae;
        set_word(8, 32'h8899AABB);
        run_access(1'b0, 2'd0, 1'b1, 9, 32'h0, 1'b1, lat, ld, ae, nrd, nwr, waited);
        checks++;
        if (lat !== 2) $display("FAIL sbyte_latency: got %0d expected 2", lat); else passed++;
        checks++;
        if (ld !== 32'hFFFFFF99) $display("FAIL sbyte_data: got %h expected ffffff99", ld); else passed++;
        checks++;
        if (ae !== 1'b0) $display("FAIL sbyte_addr_error: got %b expected 0", ae); else passed++;
        checks++;
        if (nrd !== 1 || nwr !== 0 || last_ra !== 32'h8)
            $display("FAIL sbyte_bus: got reads %0d writes %0d addr %h expected 1 0 00000008", nrd, nwr, last_ra);
        else passed++;
    endtask

    task automatic test_unsigned_half_load;
        int lat, nrd, nwr, waited;
        logic [31:0] ld;
        logic ae;
        run_access(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 1'b0, lat, ld, ae, nrd, nwr, waited);
        checks++;
        if (ld !== 32'h0000AABB || lat !== 2)
            $display("FAIL uhalf_load: got %h lat %0d expected 0000aabb lat 2", ld, lat);
        else passed++;
    endtask

    task automatic test_byte_store_rmw;
        int lat, nrd, nwr, waited;
        logic [31:0] ld;
        logic ae;
        run_access(1'b1, 2'd0, 1'b0, 32'hB, 32'h12, 1'b1, lat, ld, ae, nrd, nwr, waited);
        ref_store(2'd0, 32'hB, 32'h12);
        checks++;
        if (lat !== 3) $display("FAIL bstore_latency: got %0d expected 3", lat); else passed++;
        checks++;
        if (nrd !== 1 || nwr !== 1) $display("FAIL bstore_accesses: got reads %0d writes %0d expected 1 1", nrd, nwr);
        else passed++;
        checks++;
        if (last_wa !== 32'h8 || last_wd !== 32'h8899AA12)
            $display("FAIL bstore_write: got %h@%h expected 8899aa12@00000008", last_wd, last_wa);
        else passed++;
        checks++;
        if (mem[2] !== ref_word(8)) $display("FAIL bstore_mem: got %h expected %h", mem[2], ref_word(8));
        else passed++;
    endtask

    task automatic test_misaligned_error;
        int lat, nrd, nwr, waited;
        logic [31:0] ld;
        logic ae;
        run_access(1'b0, 2'd2, 1'b0, 6, 32'h0, 1'b0, lat, ld, ae, nrd, nwr, waited);
        checks++;
        if (lat !== 1 || ae !== 1'b1)
            $display("FAIL misaligned_word: got lat %0d err %b expected lat 1 err 1", lat, ae);
        else passed++;
        checks++;
        if (nrd !== 0 || nwr !== 0) $display("FAIL misaligned_no_mem: got reads %0d writes %0d expected 0 0", nrd, nwr);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int lat, nrd, nwr, waited;
        logic [31:0] ld;
        logic ae;
        run_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, lat, ld, ae, nrd, nwr, waited);
        ref_store(2'd2, 32'h10, 32'hDEADBEEF);
        checks++;
        if (lat !== 2 || nrd !== 0 || nwr !== 1 || last_wd !== 32'hDEADBEEF || last_wa !== 32'h10)
            $display("FAIL wstore: got lat %0d reads %0d writes %0d %h@%h expected 2 0 1 deadbeef@00000010",
                     lat, nrd, nwr, last_wd, last_wa);
        else passed++;
        run_access(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0, lat, ld, ae, nrd, nwr, waited);
        checks++;
        if (waited !== 0) $display("FAIL b2b_idle_wait: got %0d expected 0", waited); else passed++;
        checks++;
        if (ld !== 32'hDEADBEEF || lat !== 2 || ae !== 1'b0)
            $display("FAIL b2b_load: got %h lat %0d err %b expected deadbeef lat 2 err 0", ld, lat, ae);
        else passed++;
    endtask

    task automatic test_reset_during_read;
        int d0, w0;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size = 2'd1;
        bus.req_signed = 1'b0;
        bus.req_addr = 32'h12;
        bus.req_wdata = 32'h0000CAFE;
        @(negedge clock);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_memRead !== 1'b1) $display("FAIL abort_in_read: got %b expected 1", bus.mem_memRead);
        else passed++;
        d0 = done_total;
        w0 = wr_total;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL abort_idle: got busy %b done %b expected 0 0", bus.busy, bus.done);
        else passed++;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (done_total !== d0 || wr_total !== w0)
            $display("FAIL abort_no_done_write: got done %0d writes %0d expected %0d %0d", done_total, wr_total, d0, w0);
        else passed++;
        checks++;
        if (mem[4] !== ref_word(32'h10)) $display("FAIL abort_mem: got %h expected %h", mem[4], ref_word(32'h10));
        else passed++;
    endtask

    task automatic test_random;
        int lat, nrd, nwr, waited, a, elat, erd, ewr;
        logic [31:0] ld, wd, eld;
        logic ae, w, sg, bad;
        logic [1:0] sz;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 255));
            wd = $urandom;
            bad = ref_bad(sz, a);
            elat = bad ? 1 : (!w ? 2 : (sz == 2'd2 ? 2 : 3));
            erd = (bad || (w && sz == 2'd2)) ? 0 : 1;
            ewr = (!bad && w) ? 1 : 0;
            eld = (!bad && !w) ? ref_load(sz, sg, a) : 32'h0;
            run_access(w, sz, sg, a, wd, 1'($urandom_range(0, 1)), lat, ld, ae, nrd, nwr, waited);
            checks++;
            if (lat !== elat || ae !== bad)
                $display("FAIL rand_done %0d: got lat %0d err %b expected lat %0d err %b", n, lat, ae, elat, bad);
            else passed++;
            checks++;
            if (nrd !== erd || nwr !== ewr)
                $display("FAIL rand_bus %0d: got reads %0d writes %0d expected %0d %0d", n, nrd, nwr, erd, ewr);
            else passed++;
            if (!bad && !w) begin
                checks++;
                if (ld !== eld) $display("FAIL rand_load %0d: got %h expected %h", n, ld, eld);
                else passed++;
            end
            if (!bad && w) begin
                ref_store(sz, a, wd);
                checks++;
                if (mem[a / 4] !== ref_word(a))
                    $display("FAIL rand_store %0d: got %h expected %h", n, mem[a / 4], ref_word(a));
                else passed++;
            end
        end
    endtask

    task automatic test_done_pulse;
        checks++;
        if (long_done !== 0) $display("FAIL done_single_cycle: got %0d long pulses expected 0", long_done);
        else passed++;
        checks++;
        if (both_total !== 0) $display("FAIL read_write_exclusive: got %0d overlaps expected 0", both_total);
        else passed++;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        test_reset();
        init_memory();
        test_signed_byte_load();
        test_unsigned_half_load();
        test_byte_store_rmw();
        test_misaligned_error();
        test_back_to_back();
        test_reset_during_read();
        test_random();
        test_done_pulse();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port req_valid  input  1  EX/MEM presents an access this cycle.
REQ-004 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-005 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-006 SHALL have port req_signed  input  1  1 = sign-extend sub-word load, 0 = zero-extend.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-justified for byte/half.
REQ-009 SHALL have port busy  output  1  unit not idle; upstream stalls and holds request.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port load_data  output  32  extended load result, valid when done=1.
REQ-012 SHALL have port addr_error  output  1  pulses with done on misaligned/reserved access.
REQ-013 SHALL have ports mem_address  output  32, mem_writeData  output  32, mem_memWrite  output  1, mem_memRead  output  1, mem_readData  input  32  data-memory side.

Function
REQ-014 SHALL implement states IDLE, READ, WRITE, RESP; busy = (state != IDLE).
REQ-015 SHALL accept a request only in IDLE with req_valid=1; requests in other states are ignored.
REQ-016 SHALL latch size, signed, write, byte offset addr[1:0], aligned address {addr[31:2],2'b00} and wdata on acceptance; mem_address SHALL be the registered aligned address.
REQ-017 SHALL flag misalignment when half with addr[0]=1, word with addr[1:0]!=0, or size=11; such a request SHALL go IDLE->RESP with addr_error=1 and no memory access.
REQ-018 SHALL route: load -> READ; word store -> WRITE; byte/half store -> READ (read-modify-write) then WRITE.
REQ-019 SHALL drive mem_memRead=1 only in READ and mem_memWrite=1 only in WRITE, never both; both 0 elsewhere.
REQ-020 SHALL sample mem_readData at the rising edge ending READ.
REQ-021 SHALL use big-endian lanes: byte offset 0 = bits 31:24 ... offset 3 = bits 7:0; half offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-022 SHALL, for sub-word store, merge req_wdata[7:0]/[15:0] into the selected lane of the read word, other lanes unchanged; word store writes req_wdata unchanged; mem_writeData held stable throughout WRITE.
REQ-023 SHALL extract the load lane and sign- or zero-extend to 32 bits per req_signed; word loads ignore req_signed.
REQ-024 SHALL assert done for exactly one cycle in RESP, then return to IDLE; load_data and addr_error hold until next done; addr_error=0 on successful accesses.
REQ-025 SHALL complete with done at acceptance+2 cycles for loads and word stores, +3 for sub-word stores, +1 for errors.
REQ-026 SHALL accept a new request in the IDLE cycle immediately following RESP (one-access throughput per completion).

Reset
REQ-027 SHALL on reset=1 at a rising edge enter IDLE and clear busy, done, addr_error, load_data, mem_address, mem_writeData, mem_memRead, mem_memWrite to 0.
REQ-028 SHALL abandon any in-flight access on reset in any state: no done pulse, no subsequent mem_memWrite for that access.

Verification
REQ-029 SHALL cover: mem word 0x8 = 0x8899AABB, signed byte load addr 0x9 -> done at +2, load_data 0xFFFFFF99, addr_error 0.
REQ-030 SHALL cover: unsigned half load addr 0xA from 0x8899AABB -> load_data 0x0000AABB.
REQ-031 SHALL cover: byte store wdata 0x12 addr 0xB over 0x8899AABB -> one READ, one WRITE at 0x8 with 0x8899AA12, done at +3.
REQ-032 SHALL cover: word load addr 0x6 -> done at +1, addr_error 1, mem_memRead and mem_memWrite never asserted.
REQ-033 SHALL cover: word store 0xDEADBEEF addr 0x10, then load addr 0x10 accepted in next IDLE -> load_data 0xDEADBEEF.
REQ-034 SHALL cover: reset asserted during READ of a half store -> IDLE next edge, busy 0, no done, mem_memWrite stays 0.
